// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-memory responder with a byte-lane RAM and programmable
//           load latency; answers the core's mem_* request port.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           mem_addr,
    input  logic [3:0]            mem_oe,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_we,
    output logic [31:0]           mem_rdata,
    output logic                  mem_valid,
    output logic                  mem_ready,
    output logic                  misalign
);

    localparam int         c_WORDS    = 1 << (ADDR_WIDTH - 2);
    localparam bit         c_MULTI    = (LATENCY > 1);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_pend_load;
    logic [31:0]           r_pend_data;
    logic [31:0]           r_rdata;
    logic                  r_valid;
    logic                  r_misalign;

    logic [31:0]           r_mem [c_WORDS];

    logic [ADDR_WIDTH-3:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_accept;
    logic                  w_is_load;
    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_misalign;
    logic [3:0]            w_wr_lanes;
    logic [31:0]           w_wdata_sh;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_rd_shift;
    logic [31:0]           w_ld_data;
    logic                  w_resp_fire;
    logic [31:0]           w_resp_data;
    logic                  w_unused_addr;

    assign w_idx         = mem_addr[ADDR_WIDTH-1:2];
    assign w_off         = mem_addr[1:0];
    assign w_unused_addr = ^mem_addr[31:ADDR_WIDTH];

    assign w_accept  = mem_ready && (mem_oe != 4'b0000);
    assign w_is_load = (mem_we == 4'b0000);
    assign w_is_byte = (mem_oe == 4'b0001);
    assign w_is_half = (mem_oe == 4'b0011);

    // Any lane mask that is neither byte nor half behaves as a word access.
    always_comb begin
        w_misalign = 1'b0;
        w_wr_lanes = 4'b1111;
        if (w_is_byte) begin
            w_wr_lanes = 4'b0001 << w_off;
        end else if (w_is_half) begin
            w_misalign = w_off[0];
            w_wr_lanes = 4'b0011 << {w_off[1], 1'b0};
        end else begin
            w_misalign = (w_off != 2'b00);
        end
    end

    assign w_wdata_sh = mem_wdata << {w_off, 3'b000};
    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_shift = w_rd_word >> {w_off, 3'b000};

    always_comb begin
        w_ld_data = w_rd_shift;
        if (w_misalign) begin
            w_ld_data = 32'h0000_0000;
        end else if (w_is_byte) begin
            w_ld_data = {24'h00_0000, w_rd_shift[7:0]};
        end else if (w_is_half) begin
            w_ld_data = {16'h0000, w_rd_shift[15:0]};
        end
    end

    // RAM is never reset; a store accepted before reset stays written.
    always_ff @(posedge clk) begin
        if (w_accept && !w_is_load && !w_misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_lanes[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // Load data is formatted at acceptance, so later stores cannot affect it.
    assign w_resp_fire = c_MULTI ? ((r_state == c_S_BUSY) && (r_cnt == 4'd1) && r_pend_load)
                                 : (w_accept && w_is_load);
    assign w_resp_data = c_MULTI ? r_pend_data : w_ld_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (c_MULTI && w_accept) w_state_nxt = c_S_BUSY;
            c_S_BUSY: if (r_cnt == 4'd1)       w_state_nxt = c_S_IDLE;
            default:                           w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (r_state == c_S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_pend_load <= 1'b0;
            r_pend_data <= 32'h0000_0000;
            r_rdata     <= 32'h0000_0000;
            r_valid     <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_valid    <= w_resp_fire;
            r_misalign <= w_accept && w_misalign;
            if (w_resp_fire) begin
                r_rdata <= w_resp_data;
            end
            if (c_MULTI && w_accept) begin
                r_cnt       <= c_CNT_INIT;
                r_pend_load <= w_is_load;
                r_pend_data <= w_ld_data;
            end else if (r_state == c_S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_valid = r_valid;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Scoreboard bench for dmem_responder at LATENCY 1, 3 and 4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_addr  [3];
    logic [3:0]  req_oe    [3];
    logic [3:0]  req_we    [3];
    logic [31:0] req_wdata [3];
    logic [31:0] rdata     [3];
    logic        valid     [3];
    logic        ready     [3];
    logic        mis       [3];
    int          lat       [3];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(14), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .mem_addr(req_addr[0]), .mem_oe(req_oe[0]),
        .mem_wdata(req_wdata[0]), .mem_we(req_we[0]), .mem_rdata(rdata[0]),
        .mem_valid(valid[0]), .mem_ready(ready[0]), .misalign(mis[0]));

    dmem_responder #(.ADDR_WIDTH(14), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .mem_addr(req_addr[1]), .mem_oe(req_oe[1]),
        .mem_wdata(req_wdata[1]), .mem_we(req_we[1]), .mem_rdata(rdata[1]),
        .mem_valid(valid[1]), .mem_ready(ready[1]), .misalign(mis[1]));

    dmem_responder #(.ADDR_WIDTH(14), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .mem_addr(req_addr[2]), .mem_oe(req_oe[2]),
        .mem_wdata(req_wdata[2]), .mem_we(req_we[2]), .mem_rdata(rdata[2]),
        .mem_valid(valid[2]), .mem_ready(ready[2]), .misalign(mis[2]));

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mq[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response or misalign pulse must match the queue front.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (valid[k] === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected inst=%0d cyc=%0d got rdata=%h required no response",
                             k, cyc, rdata[k]);
                end else begin
                    e = sbq.pop_front();
                    if (e.inst != k || e.data !== rdata[k] || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL rsp inst=%0d cyc=%0d rdata=%h required inst=%0d cyc=%0d rdata=%h",
                                 k, cyc, rdata[k], e.inst, e.cyc, e.data);
                    end
                end
            end
            if (mis[k] === 1'b1) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL misalign_unexpected inst=%0d cyc=%0d got pulse required none", k, cyc);
                end else begin
                    e = mq.pop_front();
                    if (e.inst != k || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL misalign inst=%0d cyc=%0d required inst=%0d cyc=%0d",
                                 k, cyc, e.inst, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Present a request and hold it until accepted; expectations are queued
    // relative to the cycle in which ready was seen high.
    task automatic issue(input int k, input logic [31:0] a, input logic [3:0] oe,
                         input logic [3:0] we, input logic [31:0] wd,
                         input bit exp_ld, input logic [31:0] exp_d,
                         input bit exp_mis, output int waited);
        exp_t e;
        waited       = 0;
        req_addr[k]  = a;
        req_oe[k]    = oe;
        req_we[k]    = we;
        req_wdata[k] = wd;
        @(negedge clk);
        while (ready[k] !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst=%0d addr=%h got ready=0 required ready=1", k, a);
        end else begin
            if (exp_ld) begin
                e.inst = k; e.data = exp_d; e.cyc = cyc + lat[k];
                sbq.push_back(e);
            end
            if (exp_mis) begin
                e.inst = k; e.data = 32'h0; e.cyc = cyc + 1;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        req_oe[k] = 4'b0000;
        req_we[k] = 4'b0000;
    endtask

    task automatic op0(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we,
                       input logic [31:0] wd, input bit exp_ld, input logic [31:0] exp_d,
                       input bit exp_mis);
        int w;
        issue(0, a, oe, we, wd, exp_ld, exp_d, exp_mis, w);
        chk("l1_ready_wait", 32'(w), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        lat[0] = 1; lat[1] = 3; lat[2] = 4;
        for (int k = 0; k < 3; k++) begin
            req_addr[k] = 32'h0; req_oe[k] = 4'h0; req_we[k] = 4'h0; req_wdata[k] = 32'h0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", {31'h0, ready[k]}, 32'd1);
            chk("rst_valid", {31'h0, valid[k]}, 32'd0);
            chk("rst_misalign", {31'h0, mis[k]}, 32'd0);
            chk("rst_rdata", rdata[k], 32'h0);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=1: word, byte/half lanes, misalignment, aliasing
        op0(32'h100,  4'hF, 4'hF, 32'hDEADBEEF, 0, 32'h0,        0);
        op0(32'h100,  4'hF, 4'h0, 32'h0,        1, 32'hDEADBEEF, 0);
        op0(32'h203,  4'h1, 4'h1, 32'h11,       0, 32'h0,        0);
        op0(32'h200,  4'h3, 4'h3, 32'h2233,     0, 32'h0,        0);
        op0(32'h200,  4'hF, 4'h0, 32'h0,        1, 32'h11002233, 0);
        op0(32'h203,  4'h1, 4'h0, 32'h0,        1, 32'h00000011, 0);
        op0(32'h202,  4'h3, 4'h0, 32'h0,        1, 32'h00001100, 0);
        op0(32'h101,  4'hF, 4'hF, 32'h12345678, 0, 32'h0,        1);
        op0(32'h100,  4'hF, 4'h0, 32'h0,        1, 32'hDEADBEEF, 0);
        op0(32'h105,  4'h3, 4'h0, 32'h0,        1, 32'h00000000, 1);
        op0(32'h4000, 4'hF, 4'hF, 32'hCAFEF00D, 0, 32'h0,        0);
        op0(32'h0,    4'hF, 4'h0, 32'h0,        1, 32'hCAFEF00D, 0);
        op0(32'h4,    4'hF, 4'hF, 32'h00000055, 0, 32'h0,        0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("l1_rdata_hold", rdata[0], 32'hCAFEF00D);
        @(posedge clk);
        #1;

        // LATENCY=3: busy window and held-request backpressure
        issue(1, 32'h10, 4'hF, 4'hF, 32'hA5A5A5A5, 0, 32'h0, 0, w);
        chk("l3_first_wait", 32'(w), 32'd0);
        issue(1, 32'h10, 4'hF, 4'h0, 32'h0, 1, 32'hA5A5A5A5, 0, w);
        chk("l3_after_store_wait", 32'(w), 32'd2);
        issue(1, 32'h12, 4'h1, 4'h0, 32'h0, 1, 32'h000000A5, 0, w);
        chk("l3_backpressure_wait", 32'(w), 32'd2);
        repeat (5) @(posedge clk);
        #1;

        // LATENCY=4: reset in the middle of a pending load
        issue(2, 32'h20, 4'hF, 4'hF, 32'h0BADF00D, 0, 32'h0, 0, w);
        issue(2, 32'h20, 4'hF, 4'h0, 32'h0, 0, 32'h0, 0, w);
        chk("l4_after_store_wait", 32'(w), 32'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("l4_rst_ready", {31'h0, ready[2]}, 32'd1);
        chk("l4_rst_valid", {31'h0, valid[2]}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(2, 32'h20, 4'hF, 4'h0, 32'h0, 1, 32'h0BADF00D, 0, w);
        chk("l4_first_cycle_accept", 32'(w), 32'd0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rsp_queue_drained", 32'(sbq.size()), 32'd0);
        chk("misalign_queue_drained", 32'(mq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
